// File: rtl/decoder_pkg.sv
// Shared decode helpers: default select width, one-hot width and the one-hot function.
// Also used by the register-file select logic.
package decoder_pkg;

    localparam int unsigned DEC_WIDTH = 3;
    localparam int unsigned N         = 1 << DEC_WIDTH;

    // A shift by an unknown select yields all-X in simulation rather than a guessed bit
    function automatic logic [N-1:0] onehot(input logic [DEC_WIDTH-1:0] sel, input logic en);
        return en ? (N'(1) << sel) : '0;
    endfunction

endpackage

// File: rtl/binary_decoder_if.sv
// Select/decode bus between a select source (master) and the binary_decoder (slave).
interface binary_decoder_if #(
    parameter int unsigned WIDTH = 3
);
    localparam int unsigned N = 1 << WIDTH;

    logic             EN;
    logic [WIDTH-1:0] S;
    logic [N-1:0]     D;
    logic [N-1:0]     D_Q;
    logic             VALID_Q;

    modport master (
        output EN, S,
        input  D, D_Q, VALID_Q
    );

    modport slave (
        input  EN, S,
        output D, D_Q, VALID_Q
    );

endinterface

// File: rtl/decoder_comb.sv
// Pure combinational binary-to-one-hot stage; output is zero when en is low.
module decoder_comb
    import decoder_pkg::*;
#(
    parameter int unsigned WIDTH = DEC_WIDTH
) (
    input  logic                      en,
    input  logic [WIDTH-1:0]          sel,
    output logic [(1 << WIDTH)-1:0]   d_c
);

    localparam int unsigned NO = 1 << WIDTH;

    generate
        if (WIDTH == DEC_WIDTH) begin : g_shared
            assign d_c = onehot(sel, en);
        end else begin : g_generic
            assign d_c = en ? (NO'(1) << sel) : '0;
        end
    endgenerate

endmodule

// File: rtl/binary_decoder.sv
// One-hot decoder with a combinational output D and a registered copy D_Q/VALID_Q.
// Build option DECODER_HOLD_EN: registered outputs hold (instead of clearing) while EN=0.
module binary_decoder
    import decoder_pkg::*;
#(
    parameter int unsigned WIDTH = DEC_WIDTH
) (
    input  logic            clk,
    input  logic            reset,
    binary_decoder_if.slave bus
);

    localparam int unsigned NO = 1 << WIDTH;

    logic [NO-1:0] d_c;
    logic [NO-1:0] dq_d, dq_q;
    logic          valid_d, valid_q;

    decoder_comb #(.WIDTH(WIDTH)) u_comb (
        .en  (bus.EN),
        .sel (bus.S),
        .d_c (d_c)
    );

    // Next-state for the registered copy
    always_comb begin
        dq_d    = dq_q;
        valid_d = valid_q;
`ifdef DECODER_HOLD_EN
        if (bus.EN) begin
            dq_d    = d_c;
            valid_d = 1'b1;
        end
`else
        dq_d    = d_c;
        valid_d = bus.EN;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dq_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            dq_q    <= dq_d;
            valid_q <= valid_d;
        end
    end

    assign bus.D       = d_c;
    assign bus.D_Q     = dq_q;
    assign bus.VALID_Q = valid_q;

endmodule

// File: tb/tb_binary_decoder.sv
// Self-checking bench for binary_decoder (WIDTH=3): vector table, directed sequences, random model.
module tb_binary_decoder;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    binary_decoder_if #(.WIDTH(3)) bus ();

    binary_decoder #(.WIDTH(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [7:0] drv;
        logic [7:0] exp_d;
    } vec_t;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference decode from the rule D = 2**S when enabled, else 0
    function automatic logic [7:0] model_d(input logic en, input logic [2:0] s);
        return en ? 8'(2 ** int'(s)) : 8'h00;
    endfunction

    vec_t vecs[6];
    logic [7:0] exp_dq;
    logic       exp_v;
    logic       r_en;
    logic       r_rst;
    logic [2:0] r_s;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bus.EN   = 1'b0;
        bus.S    = '0;

        // Reset state
        tick();
        tick();
        chk("reset_dq", bus.D_Q, 8'h00);
        chk("reset_valid", {7'b0, bus.VALID_Q}, 8'h00);
        reset = 1'b0;

        // Single decode and one-cycle latency
        bus.EN = 1'b1;
        bus.S  = 3'd5;
        #1;
        chk("s5_d", bus.D, 8'b0010_0000);
        tick();
        chk("s5_dq", bus.D_Q, 8'b0010_0000);
        chk("s5_valid", {7'b0, bus.VALID_Q}, 8'h01);

        // Combinational vector table incl. boundaries and truncated wide driver
        vecs[0] = '{1'b1, 8'h00, 8'b0000_0001};
        vecs[1] = '{1'b1, 8'h07, 8'b1000_0000};
        vecs[2] = '{1'b1, 8'h0A, 8'b0000_0100};
        vecs[3] = '{1'b0, 8'h05, 8'b0000_0000};
        vecs[4] = '{1'b1, 8'h03, 8'b0000_1000};
        vecs[5] = '{1'b0, 8'hFF, 8'b0000_0000};
        for (int i = 0; i < 6; i++) begin
            bus.EN = vecs[i].en;
            bus.S  = 3'(vecs[i].drv);
            #1;
            chk($sformatf("vec%0d_d", i), bus.D, vecs[i].exp_d);
        end

        // Sweep with EN toggling under constant S
        for (int s = 0; s < 7; s++) begin
            bus.S  = 3'(s);
            bus.EN = 1'b0;
            #2;
            chk($sformatf("sweep%0d_off", s), bus.D, 8'h00);
            #3;
            bus.EN = 1'b1;
            #2;
            chk($sformatf("sweep%0d_on", s), bus.D, 8'(1 << s));
            #3;
        end

        // Reset overrides an enabled decode; D is unaffected by reset
        tick();
        reset  = 1'b1;
        bus.EN = 1'b1;
        bus.S  = 3'd3;
        tick();
        chk("rst_dq", bus.D_Q, 8'h00);
        chk("rst_valid", {7'b0, bus.VALID_Q}, 8'h00);
        chk("rst_d", bus.D, 8'b0000_1000);
        reset = 1'b0;
        tick();
        chk("post_rst_dq", bus.D_Q, 8'b0000_1000);
        chk("post_rst_valid", {7'b0, bus.VALID_Q}, 8'h01);

        // Load then drop EN for two edges
        bus.S  = 3'd4;
        bus.EN = 1'b1;
        tick();
        bus.EN = 1'b0;
        tick();
        tick();
`ifdef DECODER_HOLD_EN
        chk("drop_dq", bus.D_Q, 8'b0001_0000);
        chk("drop_valid", {7'b0, bus.VALID_Q}, 8'h01);
`else
        chk("drop_dq", bus.D_Q, 8'h00);
        chk("drop_valid", {7'b0, bus.VALID_Q}, 8'h00);
`endif

        // Random stimulus against the reference model
        exp_dq = bus.D_Q;
        exp_v  = bus.VALID_Q;
        for (int i = 0; i < 300; i++) begin
            r_en  = 1'($urandom_range(0, 1));
            r_s   = 3'($urandom_range(0, 7));
            r_rst = ($urandom_range(0, 15) == 0);
            bus.EN = r_en;
            bus.S  = r_s;
            reset  = r_rst;
            #1;
            chk("rnd_d", bus.D, model_d(r_en, r_s));
            chk("rnd_onehot0", {7'b0, 1'($onehot0(bus.D))}, 8'h01);
            if (r_rst) begin
                exp_dq = 8'h00;
                exp_v  = 1'b0;
            end else if (r_en) begin
                exp_dq = model_d(r_en, r_s);
                exp_v  = 1'b1;
            end else begin
`ifndef DECODER_HOLD_EN
                exp_dq = 8'h00;
                exp_v  = 1'b0;
`endif
            end
            tick();
            chk("rnd_dq", bus.D_Q, exp_dq);
            chk("rnd_valid", {7'b0, bus.VALID_Q}, {7'b0, exp_v});
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
